// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the
// bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int SUB_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell:
// d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor8.sv
// Bit-serial a - b - bin, LSB first,
// behind a start/ready/done handshake.
module serial_subtractor8
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t       state;
  sub_state_t       nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic             br;
  logic             am;
  logic             bm;
  logic             cd;
  logic             cb;
  logic             last;

  full_subtractor u_cell (
    .a    (ra[0]),
    .b    (rb[0]),
    .bin  (br),
    .d    (cd),
    .bout (cb)
  );

  assign last    = (cnt == LAST);
  assign res_nxt = {cd, res[WIDTH-1:1]};
  assign ready   = (state == IDLE);
  assign done    = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = SHIFT;
      SHIFT:   if (last) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      ra   <= '0;
      rb   <= '0;
      res  <= '0;
      br   <= 1'b0;
      am   <= 1'b0;
      bm   <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            ra  <= a;
            rb  <= b;
            br  <= bin;
            am  <= a[WIDTH-1];
            bm  <= b[WIDTH-1];
            res <= '0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          br  <= cb;
          res <= res_nxt;
          cnt <= cnt + CW'(1);
          // Results are published only on the final bit.
          if (last) begin
            diff <= res_nxt;
            bout <= cb;
            ovf  <= (am ^ bm) & (am ^ cd);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor8.sv
// Self-checking bench for serial_subtractor8
// against an arithmetic reference model.
module tb_serial_subtractor8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       ready;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  serial_subtractor8 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .ready (ready),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic.
  task automatic model(input logic [7:0] x,
                       input logic [7:0] y,
                       input logic c,
                       output logic [7:0] d,
                       output logic bo,
                       output logic ov);
    int ux, uy, sx, sy, s;
    ux = int'(x);
    uy = int'(y);
    sx = x[7] ? ux - 256 : ux;
    sy = y[7] ? uy - 256 : uy;
    d  = 8'((ux - uy - int'(c)) & 255);
    bo = (ux < uy + int'(c));
    s  = sx - sy - int'(c);
    ov = (s < -128) || (s > 127);
  endtask

  // Caller is at a negedge with the DUT idle.
  task automatic op(input string tag,
                    input logic [7:0] x,
                    input logic [7:0] y,
                    input logic c);
    logic [7:0] ed;
    logic eb, eo;
    model(x, y, c, ed, eb, eo);
    a = x; b = y; bin = c; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 8'h00; b = 8'h00; bin = 1'b0;
    chk({tag, ".ready_lo"}, 32'(ready), 32'd0);
    for (int i = 1; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".no_done"}, 32'(done), 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".diff"}, 32'(diff), 32'(ed));
    chk({tag, ".bout"}, 32'(bout), 32'(eb));
    chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".done_1cyc"}, 32'(done), 32'd0);
    chk({tag, ".ready_hi"}, 32'(ready), 32'd1);
    chk({tag, ".diff_hold"}, 32'(diff), 32'(ed));
  endtask

  initial begin
    logic [7:0] rx, ry;
    logic rc;
    rst_n = 1'b0; start = 1'b0;
    a = 8'h00; b = 8'h00; bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.ready", 32'(ready), 32'd1);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.diff", 32'(diff), 32'd0);
    chk("rst.bout", 32'(bout), 32'd0);
    chk("rst.ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    op("t1", 8'hDB, 8'hAA, 1'b1);
    op("t2", 8'h63, 8'h95, 1'b0);
    op("t3", 8'h00, 8'h00, 1'b1);
    op("t4", 8'h80, 8'h01, 1'b0);

    // Start while busy must be ignored.
    a = 8'h10; b = 8'h05; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("busy.ready_lo", 32'(ready), 32'd0);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("busy.done", 32'(done), 32'd1);
    chk("busy.ready_e8", 32'(ready), 32'd0);
    chk("busy.diff", 32'(diff), 32'h0B);
    chk("busy.bout", 32'(bout), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("busy.ready_e9", 32'(ready), 32'd1);
    chk("busy.no_requeue", 32'(done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("busy.idle", 32'(ready), 32'd1);

    // Reset in mid-shift aborts the operation.
    a = 8'h63; b = 8'h95; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.ready", 32'(ready), 32'd1);
    chk("mid.done", 32'(done), 32'd0);
    chk("mid.diff", 32'(diff), 32'd0);
    chk("mid.bout", 32'(bout), 32'd0);
    chk("mid.ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("mid.no_done", 32'(done), 32'd0);
    end
    op("post_rst", 8'h80, 8'h01, 1'b0);

    for (int i = 0; i < 24; i++) begin
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      op("rand", rx, ry, rc);
    end
    op("edge_ff", 8'hFF, 8'h00, 1'b0);
    op("edge_7f", 8'h7F, 8'hFF, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor8.md
# serial_subtractor8

Bit-serial two's-complement subtractor. It is the inverse-direction companion to the team's combinational 8-bit full adder. It computes A − B − Bin one bit per clock, LSB first, behind a start/ready/done handshake. It is used wherever a small-area subtract, compare or borrow-chain unit is needed next to the adder datapath, and it is exercised by the same style of self-checking testbench.

## Interface
- `WIDTH`, default 8: operand and result width in bits (≥2).
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled only when `ready`=1.
- `a` input WIDTH: minuend; captured on the accepting edge.
- `b` input WIDTH: subtrahend; captured on the accepting edge.
- `bin` input 1: borrow-in; captured on the accepting edge.
- `ready` output 1: high in IDLE only.
- `done` output 1: one-cycle completion pulse.
- `diff` output WIDTH: (a − b − bin) mod 2^WIDTH.
- `bout` output 1: unsigned borrow-out, equal to 1 iff a < b + bin.
- `ovf` output 1: signed overflow of the two's-complement subtraction.

## Operation
- The FSM has three states:
  - IDLE, where `ready`=1.
  - SHIFT, where a bit counter runs 0..WIDTH−1.
  - DONE, where `done`=1.
- IDLE→SHIFT: on a rising edge with `start`=1. Load the operand shift registers from `a`/`b`, load the borrow flop from `bin`, and clear the counter.
- SHIFT, each edge:
  - Feed bit i into the 1-bit cell: d = a_i ^ b_i ^ br; br' = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - Shift d into the result register MSB-side; shift both operands right; increment the counter.
- SHIFT→DONE: on the edge that processes bit WIDTH−1. On that same edge, register the outputs:
  - `diff` from the completed result.
  - `bout` from the final borrow.
  - `ovf` = (a_msb ^ b_msb) & (a_msb ^ d_msb), using the captured operand MSBs.
- DONE→IDLE: unconditionally on the next edge.
- `start` while `ready`=0 (SHIFT or DONE) is ignored. It is neither queued nor does it corrupt the operation in flight.
- `diff`/`bout`/`ovf` change only on the completion edge. They hold their values through later IDLE and SHIFT periods until the next completion.
- Reset (`rst_n`=0, any time, including mid-SHIFT) has immediate effect:
  - State goes to IDLE.
  - `ready`=1, `done`=0, `diff`=0, `bout`=0, `ovf`=0.
  - Counter and internal registers are cleared.
  - The aborted operation produces no `done` pulse.

## Timing
- Accepting edge E0: operands are captured and `ready` falls after E0.
- Edges E1..E(WIDTH) process bits 0..WIDTH−1.
- Results are valid and `done`=1 from E(WIDTH) until E(WIDTH+1). For WIDTH=8, `done` is high for the single cycle after E8.
- `ready` rises after E(WIDTH+1). The next `start` is accepted at E(WIDTH+2) at the earliest.
- Throughput is one operation per WIDTH+2 cycles.
- No combinational path from inputs to outputs; all outputs are registered.

## Structure
- Package `serial_sub_pkg`:
  - State typedef `sub_state_t` {IDLE, SHIFT, DONE}.
  - Constant `SUB_WIDTH_DEFAULT` = 8.
- Sub-module `full_subtractor`: a combinational 1-bit cell with inputs a, b, bin and outputs d, bout. It is instantiated once and reused every cycle.
- The top level holds the FSM, the counter sized $clog2(WIDTH), the operand and result shift registers, and the output registers.

## Test plan
- a=0xDB, b=0xAA, bin=1 → diff=0x30, bout=0, ovf=0; `done` is high for exactly the one cycle after E8.
- a=0x63, b=0x95, bin=0 → diff=0xCE, bout=1, ovf=1.
- a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1, ovf=0.
- a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, ovf=1.
- Start with a=0x10, b=0x05, then pulse `start` after E3 with a=0xFF, b=0xFF → the second request is ignored; result is diff=0x0B, bout=0; `ready` is low until after E9.
- Drop `rst_n` after E4 of an operation → `ready`=1 and `diff`/`bout`/`ovf`/`done`=0 immediately, no `done` pulse follows, and a fresh start after reset release completes correctly.
